piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is serialized first, 0 = bit 0 first.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-005 The block SHALL have port load_valid, input, 1, parallel word offered.
REQ-006 The block SHALL have port load_data, input, WIDTH, parallel word to serialize.
REQ-007 The block SHALL have port load_ready, output, 1, block can accept a word this cycle.
REQ-008 The block SHALL have port shift_en, input, 1, consumer takes the current serial bit at this edge.
REQ-009 The block SHALL have port sdo, output, 1, current serial bit.
REQ-010 The block SHALL have port sdo_valid, output, 1, sdo carries a live data bit.
REQ-011 The block SHALL have port done, output, 1, one-cycle pulse after the last bit of a word is consumed.

Function
REQ-012 The FSM SHALL have two states: IDLE and SHIFT.
REQ-013 In IDLE, load_ready SHALL be 1, sdo_valid SHALL be 0, and sdo SHALL be 0.
REQ-014 A load SHALL be accepted at a rising edge where load_valid=1 and load_ready=1; load_data is then captured into the shift register, the bit counter is set to WIDTH-1, and the state moves to SHIFT.
REQ-015 In SHIFT, sdo_valid SHALL be 1 and sdo SHALL be the head bit of the shift register (MSB or LSB per MSB_FIRST), driven combinationally from registered state.
REQ-016 sdo_valid and the first bit SHALL appear in the cycle immediately after the accepting edge (latency 1).
REQ-017 In SHIFT, an edge with shift_en=1 SHALL advance the register by one bit and decrement the counter; with shift_en=0 the register and counter SHALL hold, keeping the bit stable indefinitely.
REQ-018 The last bit SHALL be consumed at an edge with counter=0 and shift_en=1; that edge SHALL set done=1 for exactly the following cycle.
REQ-019 load_ready SHALL also be 1 in SHIFT when counter=0 and shift_en=1 (back-to-back).
REQ-020 A load accepted at the last-bit edge SHALL re-enter SHIFT with no sdo_valid bubble.
REQ-021 If no load is accepted at the last-bit edge, the state SHALL return to IDLE.
REQ-022 load_valid in SHIFT with load_ready=0 SHALL be ignored, and load_data SHALL not affect the register.
REQ-023 shift_en in IDLE SHALL have no effect.
REQ-024 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap below 0.

Reset
REQ-025 While reset=1 at an edge, the block SHALL go to IDLE, clear the shift register and counter, set done=0, and ignore load_valid and shift_en.
REQ-026 After reset, outputs SHALL be load_ready=1, sdo=0, sdo_valid=0, done=0.
REQ-027 Reset asserted mid-word SHALL abort the word with no done pulse, and the remaining bits SHALL be discarded.

Structure
REQ-028 Shared package piso_pkg SHALL hold the state enum (IDLE, SHIFT) and the default WIDTH constant.
REQ-029 The down-counter SHALL be a sub-module bit_counter (load, decrement-enable, zero flag), instantiated once.
REQ-030 All state SHALL be in a single clocked process; sdo, sdo_valid, and load_ready SHALL be combinational from state.

Verification
REQ-031 Test 1 (WIDTH=8, MSB_FIRST=1): load 0xA5 with shift_en held at 1 -> sdo = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, done=1 on the 9th cycle, then IDLE.
REQ-032 Test 2: load 0xA5 with shift_en=0 for 5 cycles after the 3rd bit -> sdo holds 1 during the stall, then the sequence resumes intact, 8 bits total.
REQ-033 Test 3: back-to-back 0xA5 then 0x3C, with load_valid held and shift_en=1 -> 16 contiguous valid bits 10100101 00111100, sdo_valid never drops, done pulses after bit 8 and bit 16.
REQ-034 Test 4: reset high for 1 cycle after 3 bits of 0xFF -> next cycle sdo_valid=0, sdo=0, load_ready=1, and no done pulse.
REQ-035 Test 5 (MSB_FIRST=0): load 0x01 -> sdo = 1,0,0,0,0,0,0,0.
REQ-036 Test 6: load_valid with 0x55 while in SHIFT mid-word -> ignored, the current word finishes unchanged, and no second word is sent.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in / serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    localparam int PISO_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_tx_bit_counter.sv
// Down-counter of bits remaining in the current word.
// A load takes priority over a decrement, and the count saturates at zero.
module bit_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: reload, saturating decrement, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter with a load handshake.
// A word is presented one bit at a time on sdo and advances only when the
// consumer asserts shift_en. A new word can be accepted at the same edge
// that consumes the last bit of the current word, so back-to-back words
// stream without a gap.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    piso_state_e      state_q;
    piso_state_e      state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic             done_q;
    logic             done_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             last_bit;
    logic             accept;

    bit_counter #(
        .CW (CW)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CW'(WIDTH - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state, handshake and serial-output logic.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        // The edge that takes the final bit frees the register for a new word.
        last_bit   = (state_q == SHIFT) && cnt_zero && shift_en;
        load_ready = (state_q == IDLE) || last_bit;
        accept     = load_valid && load_ready;

        if ((state_q == SHIFT) && shift_en) begin
            if (MSB_FIRST != 0) begin
                sreg_d = sreg_q << 1;
            end else begin
                sreg_d = sreg_q >> 1;
            end
            if (cnt_zero) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                cnt_dec = 1'b1;
            end
        end

        // A fresh load overrides the shift and any return to IDLE.
        if (accept) begin
            sreg_d   = load_data;
            state_d  = SHIFT;
            cnt_load = 1'b1;
        end

        sdo_valid = (state_q == SHIFT);
        if (state_q == SHIFT) begin
            sdo = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
        end else begin
            sdo = 1'b0;
        end
    end

    // State, shift register and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: an MSB-first and an LSB-first instance share stimulus.
// Stimulus pushes hand-computed bit sequences into per-instance queues; a
// monitor pops one entry for every bit the consumer takes and checks done.
module tb_piso_tx;

    typedef struct {
        logic b;
        logic last;
    } exp_bit_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_data;
    logic       shift_en;

    logic load_ready_m, sdo_m, sdo_valid_m, done_m;
    logic load_ready_l, sdo_l, sdo_valid_l, done_l;

    exp_bit_t q_m[$];
    exp_bit_t q_l[$];
    logic     exp_done_m = 1'b0;
    logic     exp_done_l = 1'b0;

    int nchecks = 0;
    int nerrors = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready_m),
        .shift_en   (shift_en),
        .sdo        (sdo_m),
        .sdo_valid  (sdo_valid_m),
        .done       (done_m)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready_l),
        .shift_en   (shift_en),
        .sdo        (sdo_l),
        .sdo_valid  (sdo_valid_l),
        .done       (done_l)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: done is checked every cycle against the consumption seen one
    // cycle earlier; each consumed bit is popped and compared.
    always @(negedge clk) begin
        exp_bit_t e;
        chk("done_msb", done_m, exp_done_m);
        chk("done_lsb", done_l, exp_done_l);
        exp_done_m = 1'b0;
        exp_done_l = 1'b0;
        if (!reset && shift_en && sdo_valid_m) begin
            if (q_m.size() == 0) begin
                chk("unexpected_bit_msb", 1'b1, 1'b0);
            end else begin
                e = q_m.pop_front();
                chk("sdo_msb", sdo_m, e.b);
                exp_done_m = e.last;
            end
        end
        if (!reset && shift_en && sdo_valid_l) begin
            if (q_l.size() == 0) begin
                chk("unexpected_bit_lsb", 1'b1, 1'b0);
            end else begin
                e = q_l.pop_front();
                chk("sdo_lsb", sdo_l, e.b);
                exp_done_l = e.last;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // seq_m / seq_l: expected serial order for each instance, first bit in [7].
    task automatic push(input logic [7:0] seq_m, input logic [7:0] seq_l);
        for (int i = 7; i >= 0; i--) begin
            q_m.push_back('{b: seq_m[i], last: (i == 0)});
            q_l.push_back('{b: seq_l[i], last: (i == 0)});
        end
    endtask

    task automatic send(input logic [7:0] w, input logic [7:0] seq_m, input logic [7:0] seq_l);
        load_valid = 1'b1;
        load_data  = w;
        push(seq_m, seq_l);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, "_ready_m"}, load_ready_m, 1'b1);
        chk({tag, "_valid_m"}, sdo_valid_m, 1'b0);
        chk({tag, "_sdo_m"}, sdo_m, 1'b0);
        chk({tag, "_ready_l"}, load_ready_l, 1'b1);
        chk({tag, "_valid_l"}, sdo_valid_l, 1'b0);
        chk({tag, "_sdo_l"}, sdo_l, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        shift_en   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_idle("reset");
        chk("reset_done_m", done_m, 1'b0);

        // Test 1: 0xA5, shift_en held high; first bit right after accept.
        shift_en = 1'b1;
        send(8'hA5, 8'b10100101, 8'b10100101);
        @(negedge clk);
        chk("t1_latency_valid", sdo_valid_m, 1'b1);
        chk("t1_first_bit", sdo_m, 1'b1);
        chk("t1_busy_ready", load_ready_m, 1'b0);
        repeat (9) tick();
        chk_idle("t1_idle");

        // Test 2: stall 5 cycles while the third bit (1) is presented.
        send(8'hA5, 8'b10100101, 8'b10100101);
        tick();
        tick();
        shift_en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t2_stall_sdo", sdo_m, 1'b1);
            chk("t2_stall_valid", sdo_valid_m, 1'b1);
            tick();
        end
        shift_en = 1'b1;
        repeat (8) tick();
        chk_idle("t2_idle");

        // Test 3: back-to-back 0xA5 then 0x3C with load_valid held.
        send(8'hA5, 8'b10100101, 8'b10100101);
        load_valid = 1'b1;
        load_data  = 8'h3C;
        push(8'b00111100, 8'b00111100);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("t3_no_bubble", sdo_valid_m, 1'b1);
            tick();
            if (i == 7) load_valid = 1'b0;
        end
        chk_idle("t3_idle");

        // Test 4: reset after 3 bits of 0xFF aborts the word silently.
        send(8'hFF, 8'hFF, 8'hFF);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q_m.delete();
        q_l.delete();
        chk_idle("t4_abort");
        chk("t4_no_done", done_m, 1'b0);
        repeat (3) tick();

        // Test 5: 0x01, LSB-first instance emits the 1 first.
        send(8'h01, 8'b00000001, 8'b10000000);
        repeat (9) tick();
        chk_idle("t5_idle");

        // Test 6: a load offered mid-word is ignored.
        send(8'h0F, 8'b00001111, 8'b11110000);
        repeat (3) tick();
        load_valid = 1'b1;
        load_data  = 8'h55;
        @(negedge clk);
        chk("t6_busy_ready", load_ready_m, 1'b0);
        tick();
        tick();
        load_valid = 1'b0;
        repeat (8) tick();
        chk_idle("t6_idle");
        repeat (4) tick();

        chk("queue_m_drained", q_m.size() == 0, 1'b1);
        chk("queue_l_drained", q_l.size() == 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
